dmem_ctrl: RTL
==============

# dmem_ctrl

Data-memory port controller for the 32I pipeline. Sits directly downstream of the MEM stage and takes its address, size, write data and read/write strobes. Converts each access into a single valid/ready transaction on the data-memory bus, with byte enables and lane-aligned write data. Stalls the pipeline until the bus completes, then returns sign- or zero-extended load data.

## Interface
Parameters: none. Widths are fixed at 32-bit address and data.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_addr  in  32  byte address from MEM stage
- req_wdata  in  32  store data, right-justified
- req_size  in  2  00 word, 01 half, 10 byte; 11 treated as word
- req_read  in  1  load request
- req_write  in  1  store request; wins if both strobes are high
- req_unsigned  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend
- stall  out  1  hold pipeline registers upstream of this block
- misaligned  out  1  combinational; the current request is misaligned
- rdata  out  32  extended load data, registered
- rdata_valid  out  1  one-cycle pulse when rdata is updated by a completed load
- bus_valid  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address; {req_addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ready  in  1  transaction accepted/completed this cycle
- bus_rdata  in  32  read word; sampled only when bus_valid & bus_ready & !bus_we

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE behaviour:
  - A request is present when req_read|req_write is high.
  - If the request is aligned: latch addr, we, be, wdata, size and unsigned; go to REQ.
  - If the request is misaligned: stay in IDLE and issue no bus access.
- REQ behaviour:
  - bus_valid=1 with latched fields held stable.
  - On bus_ready: if the access is a read, register the extended bus_rdata into rdata. Go to DONE.
- DONE behaviour:
  - stall=0; the pipeline advances this cycle.
  - The request inputs still hold the old access and are ignored.
  - Next state is IDLE unconditionally.
- stall = (IDLE & request & !misaligned) | REQ.
- misaligned = request & ((size==half & addr[0]) | (size is word & addr[1:0]!=0)). stall=0 for a misaligned request; exception handling belongs to the pipeline.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Write data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: unchanged
- Load extraction:
  - Select the byte lane by addr[1:0], or the halfword by addr[1].
  - Extend to 32 bits from bit 7 (byte) or bit 15 (half); zero-fill if req_unsigned=1.
  - Word loads pass through unchanged.
- rdata holds its value until the next completed load; stores never change rdata.
- rdata_valid=1 only in DONE following a read.

## Timing
- Reset values: state IDLE, bus_valid 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, rdata 0, rdata_valid 0.
- stall and misaligned are combinational from state and inputs.
- Aligned request with zero-wait bus:
  - cycle 0: IDLE, stall=1
  - cycle 1: REQ, bus_valid=1, bus_ready=1
  - cycle 2: DONE, stall=0, rdata valid
  - Three cycles per access; two stall cycles.
- Each wait cycle (bus_ready=0 in REQ) adds one cycle. Latency is unbounded; there is no timeout.
- Bus rule: once bus_valid=1, it and bus_we, bus_addr, bus_be and bus_wdata stay constant until the cycle bus_ready=1 is sampled.
- bus_valid drops the cycle after acceptance.
- Back-to-back memory instructions: the new request is seen in IDLE the cycle after DONE. There is no bus gap beyond the FSM's own cycles.
- bus_ready while not in REQ is ignored.
- rst in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - An in-flight bus access is abandoned; bus_valid is low the cycle after rst.

## Test plan
- **Word load, zero wait:** req_read, addr 0x100, size 00; bus_ready=1 in first REQ cycle with bus_rdata 0xDEADBEEF.
  - bus_addr 0x100, be 1111.
  - stall high 2 cycles, then rdata=0xDEADBEEF with rdata_valid pulse.
- **Byte loads, signed and unsigned:** addr 0x103 on bus_rdata 0x80FF7F01.
  - Signed: rdata=0xFFFFFF80.
  - Unsigned: rdata=0x00000080.
  - addr 0x101 signed: rdata=0x0000007F.
- **Half store with wait states:** req_write, addr 0x202, size 01, wdata 0x1234ABCD; bus_ready low 3 cycles.
  - be 1100, bus_wdata 0xABCDABCD, held stable throughout.
  - stall high for 5 cycles total.
- **Misaligned accesses:** word read at 0x101, half at 0x003.
  - misaligned=1, stall=0, bus_valid never asserted, rdata unchanged.
- **Back-to-back accesses:** store to 0x10 followed by load from 0x14.
  - Two distinct bus transactions.
  - No duplicate access issued during DONE.
  - Loaded value appears only after the second DONE.
- **Reset mid-transaction:** rst in REQ with bus_ready held low.
  - Next cycle: bus_valid=0, stall=0 (no request present), rdata=0.
  - A new request after reset completes normally.

Source files
------------

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : MEM-stage to data-memory bus controller (valid/ready, lane steering,
//            load extension, pipeline stall).
// Revision : 1.0
// ============================================================================
module dmem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        req_unsigned,
    output logic        stall,
    output logic        misaligned,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  lane_q;
    logic        we_q;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] rdata_q, load_d;
    logic        rdata_valid_q;

    logic        req_present;
    logic        is_half, is_byte, is_word;
    logic        start;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_present = req_read | req_write;
    assign is_half     = (req_size == SZ_HALF);
    assign is_byte     = (req_size == SZ_BYTE);
    assign is_word     = !is_half && !is_byte;
    assign misaligned  = req_present &
                         ((is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00)));
    assign start       = (state_q == ST_IDLE) && req_present && !misaligned;

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = req_wdata;
        if (is_byte) begin
            be_d    = 4'b0001 << req_addr[1:0];
            wdata_d = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{req_wdata[15:0]}};
        end
    end

    // Lane select and extension use the latched access, not the live request.
    always_comb begin
        ld_byte = bus_rdata[7:0];
        case (lane_q)
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            2'd3:    ld_byte = bus_rdata[31:24];
            default: ld_byte = bus_rdata[7:0];
        endcase
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_d  = bus_rdata;
        if (size_q == SZ_BYTE) begin
            load_d = {{24{ld_byte[7] & !uns_q}}, ld_byte};
        end else if (size_q == SZ_HALF) begin
            load_d = {{16{ld_half[15] & !uns_q}}, ld_half};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (bus_ready) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_valid = (state_q == ST_REQ);
        stall     = start || (state_q == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= 32'd0;
            lane_q        <= 2'd0;
            we_q          <= 1'b0;
            be_q          <= 4'd0;
            wdata_q       <= 32'd0;
            size_q        <= 2'd0;
            uns_q         <= 1'b0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            if (start) begin
                addr_q  <= {req_addr[31:2], 2'b00};
                lane_q  <= req_addr[1:0];
                we_q    <= req_write;
                be_q    <= be_d;
                wdata_q <= wdata_d;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
            end
            if ((state_q == ST_REQ) && bus_ready && !we_q) begin
                rdata_q       <= load_d;
                rdata_valid_q <= 1'b1;
            end
        end
    end

    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule
`default_nettype wire
